// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file writeback arbiter.
// Holds the default data/address widths, the zero-register address and
// the {addr, data} entry layout used for queued long-latency results.
package regfile_pkg;

  localparam int WIDTH      = 32;
  localparam int ADDR_WIDTH = 5;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [WIDTH-1:0]      data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Result queue for long-latency writebacks: circular buffer with
// registered storage, push/pop and an occupancy count.
// Optional macro WB_FWD_EN adds two combinational lookups that return the
// youngest queued entry matching a nonzero register address.
module wb_fifo
  import regfile_pkg::*;
#(
  parameter int width      = WIDTH,
  parameter int addr_width = ADDR_WIDTH,
  parameter int depth      = 2,
  parameter int cnt_width  = $clog2(depth + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [addr_width-1:0] push_addr,
  input  logic [width-1:0]      push_data,
  input  logic                  pop,
  output logic [addr_width-1:0] head_addr,
  output logic [width-1:0]      head_data,
  output logic [cnt_width-1:0]  count
`ifdef WB_FWD_EN
  ,
  input  logic [addr_width-1:0] lk_addr1,
  input  logic [addr_width-1:0] lk_addr2,
  output logic                  lk_hit1,
  output logic                  lk_hit2,
  output logic [width-1:0]      lk_data1,
  output logic [width-1:0]      lk_data2
`endif
);

  localparam int PW = (depth > 1) ? $clog2(depth) : 1;
  localparam logic [cnt_width-1:0] FULL_C  = cnt_width'(depth);
  localparam logic [cnt_width-1:0] CNT_ONE = cnt_width'(1);
  localparam logic [cnt_width-1:0] CNT_ZERO = cnt_width'(0);
  localparam logic [PW-1:0]        LAST_C  = PW'(depth - 1);
  localparam logic [PW-1:0]        PTR_ONE = PW'(1);
  localparam logic [PW-1:0]        PTR_ZERO = PW'(0);

  logic [addr_width-1:0] mem_addr_r [depth];
  logic [width-1:0]      mem_data_r [depth];
  logic [PW-1:0]         rd_ptr_r;
  logic [PW-1:0]         wr_ptr_r;
  logic [cnt_width-1:0]  count_r;
  logic                  push_ok_s;
  logic                  pop_ok_s;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    if (p == LAST_C) begin
      return PTR_ZERO;
    end else begin
      return p + PTR_ONE;
    end
  endfunction

  // Refuse pushes into a full queue and pops from an empty one.
  always_comb begin
    push_ok_s = push && (count_r != FULL_C) && !rst;
    pop_ok_s  = pop && (count_r != CNT_ZERO);
  end

  // Pointer and occupancy bookkeeping; reset empties the queue.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_r <= PTR_ZERO;
      wr_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= ptr_next(wr_ptr_r);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= ptr_next(rd_ptr_r);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; contents are only meaningful while counted as valid.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_addr_r[wr_ptr_r] <= push_addr;
      mem_data_r[wr_ptr_r] <= push_data;
    end
  end

  assign head_addr = mem_addr_r[rd_ptr_r];
  assign head_data = mem_data_r[rd_ptr_r];
  assign count     = count_r;

`ifdef WB_FWD_EN
  // Scan oldest to youngest so the youngest matching entry wins.
  always_comb begin
    lk_hit1  = 1'b0;
    lk_hit2  = 1'b0;
    lk_data1 = {width{1'b0}};
    lk_data2 = {width{1'b0}};
    for (int i = 0; i < depth; i++) begin
      int slot;
      slot = int'(rd_ptr_r) + i;
      if (slot >= depth) begin
        slot = slot - depth;
      end else begin
        slot = slot;
      end
      if (i < int'(count_r)) begin
        if ((lk_addr1 != addr_width'(REG_ZERO)) && (mem_addr_r[PW'(slot)] == lk_addr1)) begin
          lk_hit1  = 1'b1;
          lk_data1 = mem_data_r[PW'(slot)];
        end else begin
          lk_hit1 = lk_hit1;
        end
        if ((lk_addr2 != addr_width'(REG_ZERO)) && (mem_addr_r[PW'(slot)] == lk_addr2)) begin
          lk_hit2  = 1'b1;
          lk_data2 = mem_data_r[PW'(slot)];
        end else begin
          lk_hit2 = lk_hit2;
        end
      end else begin
        lk_hit1 = lk_hit1;
      end
    end
  end
`endif

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: merges pipeline writebacks with
// long-latency (mult/div) results into one registered write port.
// Priority: pipeline write to a nonzero register, then the oldest queued
// result, then a same-cycle result bypassing an empty queue.
// Optional macro WB_FWD_EN adds two forwarding lookup ports.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int width      = WIDTH,
  parameter int addr_width = ADDR_WIDTH,
  parameter int depth      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pipe_we,
  input  logic [addr_width-1:0] pipe_addr,
  input  logic [width-1:0]      pipe_data,
  input  logic                  lu_valid,
  input  logic [addr_width-1:0] lu_addr,
  input  logic [width-1:0]      lu_data,
  output logic                  lu_ready,
  output logic                  pipe_stall,
  output logic                  RegWrite,
  output logic [addr_width-1:0] W_addr,
  output logic [width-1:0]      W_data
`ifdef WB_FWD_EN
  ,
  input  logic [addr_width-1:0] fwd_addr1,
  input  logic [addr_width-1:0] fwd_addr2,
  output logic                  fwd_hit1,
  output logic                  fwd_hit2,
  output logic [width-1:0]      fwd_data1,
  output logic [width-1:0]      fwd_data2
`endif
);

  localparam int CNT_W = $clog2(depth + 1);
  localparam logic [CNT_W-1:0]      FULL_C = CNT_W'(depth);
  localparam logic [CNT_W-1:0]      EMPTY_C = CNT_W'(0);
  localparam logic [addr_width-1:0] ZERO_C = addr_width'(REG_ZERO);

  logic [CNT_W-1:0]      count_s;
  logic [addr_width-1:0] head_addr_s;
  logic [width-1:0]      head_data_s;
  logic                  pipe_win_s;
  logic                  lu_take_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  wr_en_s;
  logic [addr_width-1:0] wr_addr_s;
  logic [width-1:0]      wr_data_s;

`ifdef WB_FWD_EN
  logic                  q_hit1_s;
  logic                  q_hit2_s;
  logic [width-1:0]      q_data1_s;
  logic [width-1:0]      q_data2_s;
`endif

  wb_fifo #(
    .width      (width),
    .addr_width (addr_width),
    .depth      (depth),
    .cnt_width  (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .push_addr (lu_addr),
    .push_data (lu_data),
    .pop       (pop_s),
    .head_addr (head_addr_s),
    .head_data (head_data_s),
    .count     (count_s)
`ifdef WB_FWD_EN
    ,
    .lk_addr1  (fwd_addr1),
    .lk_addr2  (fwd_addr2),
    .lk_hit1   (q_hit1_s),
    .lk_hit2   (q_hit2_s),
    .lk_data1  (q_data1_s),
    .lk_data2  (q_data2_s)
`endif
  );

  // Handshake and stall status come straight from the registered count.
  always_comb begin
    lu_ready   = (count_s < FULL_C) && !rst;
    pipe_stall = (count_s == FULL_C);
    pipe_win_s = pipe_we && (pipe_addr != ZERO_C);
    lu_take_s  = lu_valid && lu_ready && (lu_addr != ZERO_C);
  end

  // Pick the single write for this cycle; an accepted result that does
  // not bypass goes to the queue tail so acceptance order is kept.
  always_comb begin
    wr_en_s   = 1'b0;
    wr_addr_s = {addr_width{1'b0}};
    wr_data_s = {width{1'b0}};
    push_s    = 1'b0;
    pop_s     = 1'b0;
    if (pipe_win_s) begin
      wr_en_s   = 1'b1;
      wr_addr_s = pipe_addr;
      wr_data_s = pipe_data;
      push_s    = lu_take_s;
    end else if (count_s != EMPTY_C) begin
      wr_en_s   = 1'b1;
      wr_addr_s = head_addr_s;
      wr_data_s = head_data_s;
      pop_s     = 1'b1;
      push_s    = lu_take_s;
    end else if (lu_take_s) begin
      wr_en_s   = 1'b1;
      wr_addr_s = lu_addr;
      wr_data_s = lu_data;
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Registered write port; address/data hold when no write is issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      RegWrite <= 1'b0;
      W_addr   <= {addr_width{1'b0}};
      W_data   <= {width{1'b0}};
    end else begin
      RegWrite <= wr_en_s;
      if (wr_en_s) begin
        W_addr <= wr_addr_s;
        W_data <= wr_data_s;
      end else begin
        W_addr <= W_addr;
        W_data <= W_data;
      end
    end
  end

`ifdef WB_FWD_EN
  // Forwarding: youngest queued match first, else the pending write.
  always_comb begin
    fwd_hit1  = 1'b0;
    fwd_hit2  = 1'b0;
    fwd_data1 = {width{1'b0}};
    fwd_data2 = {width{1'b0}};
    if (q_hit1_s) begin
      fwd_hit1  = 1'b1;
      fwd_data1 = q_data1_s;
    end else if (RegWrite && (fwd_addr1 != ZERO_C) && (fwd_addr1 == W_addr)) begin
      fwd_hit1  = 1'b1;
      fwd_data1 = W_data;
    end else begin
      fwd_hit1 = 1'b0;
    end
    if (q_hit2_s) begin
      fwd_hit2  = 1'b1;
      fwd_data2 = q_data2_s;
    end else if (RegWrite && (fwd_addr2 != ZERO_C) && (fwd_addr2 == W_addr)) begin
      fwd_hit2  = 1'b1;
      fwd_data2 = W_data;
    end else begin
      fwd_hit2 = 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: directed vectors push the
// expected writes (with their expected cycle) into a queue, and a monitor
// on the falling edge pops and compares every register-file write.
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  typedef struct {
    int        cyc;
    wb_entry_t ent;
  } exp_t;

  logic             clk;
  logic             rst;
  logic             pipe_we;
  logic [4:0]       pipe_addr;
  logic [31:0]      pipe_data;
  logic             lu_valid;
  logic [4:0]       lu_addr;
  logic [31:0]      lu_data;
  logic             lu_ready;
  logic             pipe_stall;
  logic             RegWrite;
  logic [4:0]       W_addr;
  logic [31:0]      W_data;
`ifdef WB_FWD_EN
  logic [4:0]       fwd_addr1;
  logic [4:0]       fwd_addr2;
  logic             fwd_hit1;
  logic             fwd_hit2;
  logic [31:0]      fwd_data1;
  logic [31:0]      fwd_data2;
`endif

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  exp_t sb[$];
  exp_t mon_e;

  regfile_wb_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .pipe_we    (pipe_we),
    .pipe_addr  (pipe_addr),
    .pipe_data  (pipe_data),
    .lu_valid   (lu_valid),
    .lu_addr    (lu_addr),
    .lu_data    (lu_data),
    .lu_ready   (lu_ready),
    .pipe_stall (pipe_stall),
    .RegWrite   (RegWrite),
    .W_addr     (W_addr),
    .W_data     (W_data)
`ifdef WB_FWD_EN
    ,
    .fwd_addr1  (fwd_addr1),
    .fwd_addr2  (fwd_addr2),
    .fwd_hit1   (fwd_hit1),
    .fwd_hit2   (fwd_hit2),
    .fwd_data1  (fwd_data1),
    .fwd_data2  (fwd_data2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic expect_wr(input int c, input logic [4:0] a, input logic [31:0] d);
    exp_t e;
    e.cyc      = c;
    e.ent.addr = a;
    e.ent.data = d;
    sb.push_back(e);
  endtask

  task automatic drive(input logic pwe, input logic [4:0] pa, input logic [31:0] pd,
                       input logic lv, input logic [4:0] la, input logic [31:0] ld);
    pipe_we   = pwe;
    pipe_addr = pa;
    pipe_data = pd;
    lu_valid  = lv;
    lu_addr   = la;
    lu_data   = ld;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every write must match the scoreboard head, on its cycle.
  always @(negedge clk) begin
    if (RegWrite === 1'b1) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_write: got addr %0d data 0x%0h at cycle %0d, expected no write",
                 W_addr, W_data, cyc);
      end else begin
        mon_e = sb.pop_front();
        if ((mon_e.cyc != cyc) || (W_addr !== mon_e.ent.addr) || (W_data !== mon_e.ent.data)) begin
          n_errors++;
          $display("FAIL write: got cycle %0d addr %0d data 0x%0h, expected cycle %0d addr %0d data 0x%0h",
                   cyc, W_addr, W_data, mon_e.cyc, mon_e.ent.addr, mon_e.ent.data);
        end
      end
    end else if ((sb.size() > 0) && (sb[0].cyc <= cyc)) begin
      n_checks++;
      n_errors++;
      mon_e = sb.pop_front();
      $display("FAIL missing_write: got no write at cycle %0d, expected addr %0d data 0x%0h",
               cyc, mon_e.ent.addr, mon_e.ent.data);
    end
  end

  initial begin
    int c;
`ifdef WB_FWD_EN
    fwd_addr1 = 5'd0;
    fwd_addr2 = 5'd0;
`endif
    // Reset with live-looking inputs that must be ignored.
    rst = 1'b1;
    drive(1'b1, 5'd3, 32'hFFFF, 1'b1, 5'd4, 32'hEEEE);
    tick();
    tick();
    @(negedge clk);
    check("rst_regwrite", {31'd0, RegWrite}, 32'd0);
    check("rst_w_addr", {27'd0, W_addr}, 32'd0);
    check("rst_w_data", W_data, 32'd0);
    check("rst_pipe_stall", {31'd0, pipe_stall}, 32'd0);
    check("rst_lu_ready", {31'd0, lu_ready}, 32'd0);
    tick();
    rst = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    tick();

    // Plain pipeline write.
    drive(1'b1, 5'd8, 32'h1234, 1'b0, 5'd0, 32'd0);
    expect_wr(cyc + 1, 5'd8, 32'h1234);
    tick();

    // Bypass into an empty queue.
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd16, 32'hA5);
    expect_wr(cyc + 1, 5'd16, 32'hA5);
    @(negedge clk);
    check("bypass_lu_ready", {31'd0, lu_ready}, 32'd1);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    tick();
    @(negedge clk);
    check("bypass_no_stall", {31'd0, pipe_stall}, 32'd0);
    tick();

    // Pipeline busy for 4 cycles, two results queue up and fill it.
    c = cyc;
    for (int i = 0; i < 4; i++) begin
      expect_wr(c + 1 + i, 5'(1 + i), 32'h100 + i);
    end
    expect_wr(c + 5, 5'd20, 32'hB0);
    expect_wr(c + 6, 5'd21, 32'hB1);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 5'(1 + i), 32'h100 + i, (i < 3), 5'(20 + i), 32'hB0 + i);
      if (i >= 2) begin
        @(negedge clk);
        check("full_lu_ready", {31'd0, lu_ready}, 32'd0);
        check("full_pipe_stall", {31'd0, pipe_stall}, 32'd1);
      end
      tick();
    end
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    check("drain_start_stall", {31'd0, pipe_stall}, 32'd1);
    tick();
    tick();
    @(negedge clk);
    check("drained_stall", {31'd0, pipe_stall}, 32'd0);
    check("drained_lu_ready", {31'd0, lu_ready}, 32'd1);
    tick();

    // Pipeline write to r0 yields to the queue head; push+pop keeps count;
    // a result to r0 is dropped.
    c = cyc;
    expect_wr(c + 1, 5'd5, 32'h55);
    expect_wr(c + 2, 5'd9, 32'h77);
    expect_wr(c + 3, 5'd10, 32'h88);
    drive(1'b1, 5'd5, 32'h55, 1'b1, 5'd9, 32'h77);
    tick();
    drive(1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd10, 32'h88);
    @(negedge clk);
    check("head_lu_ready", {31'd0, lu_ready}, 32'd1);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h99);
    @(negedge clk);
    check("pushpop_no_stall", {31'd0, pipe_stall}, 32'd0);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    tick();
    tick();

    // Fill the queue, then reset: queued results must never appear.
    c = cyc;
    expect_wr(c + 1, 5'd6, 32'h66);
    expect_wr(c + 2, 5'd7, 32'h77);
    drive(1'b1, 5'd6, 32'h66, 1'b1, 5'd25, 32'hC5);
    tick();
    drive(1'b1, 5'd7, 32'h77, 1'b1, 5'd26, 32'hC6);
    tick();
    rst = 1'b1;
    drive(1'b1, 5'd11, 32'hBB, 1'b1, 5'd12, 32'hCC);
    @(negedge clk);
    check("prerst_stall", {31'd0, pipe_stall}, 32'd1);
    check("inrst_lu_ready", {31'd0, lu_ready}, 32'd0);
    tick();
    rst = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    check("postrst_regwrite", {31'd0, RegWrite}, 32'd0);
    check("postrst_stall", {31'd0, pipe_stall}, 32'd0);
    check("postrst_w_addr", {27'd0, W_addr}, 32'd0);
    check("postrst_lu_ready", {31'd0, lu_ready}, 32'd1);
    tick();
    tick();
    tick();

    // r0 pipeline write with empty queue: result bypasses; then a dropped
    // r0 result, and the write port holds its last address/data.
    c = cyc;
    expect_wr(c + 1, 5'd12, 32'h12);
    drive(1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd12, 32'h12);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h33);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    check("hold_regwrite", {31'd0, RegWrite}, 32'd0);
    check("hold_w_addr", {27'd0, W_addr}, 32'd12);
    check("hold_w_data", W_data, 32'h12);
    tick();

`ifdef WB_FWD_EN
    // Forwarding from the queue and from the pending registered write.
    c = cyc;
    expect_wr(c + 1, 5'd2, 32'h22);
    expect_wr(c + 2, 5'd3, 32'h33);
    expect_wr(c + 3, 5'd17, 32'h5);
    drive(1'b1, 5'd2, 32'h22, 1'b1, 5'd17, 32'h5);
    tick();
    drive(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'd0);
    fwd_addr1 = 5'd17;
    fwd_addr2 = 5'd0;
    @(negedge clk);
    check("fwd_hit1", {31'd0, fwd_hit1}, 32'd1);
    check("fwd_data1", fwd_data1, 32'h5);
    check("fwd_hit2_zero", {31'd0, fwd_hit2}, 32'd0);
    fwd_addr2 = 5'd2;
    #1;
    check("fwd_hit2_pending", {31'd0, fwd_hit2}, 32'd1);
    check("fwd_data2_pending", fwd_data2, 32'h22);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    fwd_addr1 = 5'd0;
    fwd_addr2 = 5'd0;
    tick();
    tick();
`endif

    repeat (4) tick();
    check("scoreboard_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset (clk, rst); all state SHALL update on the rising edge of clk.
REQ-002 Parameters SHALL be: width, default 32, data width; addr_width, default 5, register address width; depth, default 2, long-latency result queue entries.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 pipe_we  input  1  pipeline writeback request; always accepted, no ready signal.
REQ-006 pipe_addr  input  addr_width  destination register of the pipeline write.
REQ-007 pipe_data  input  width  data for the pipeline write.
REQ-008 lu_valid  input  1  long-latency unit (mult/div) result valid.
REQ-009 lu_addr  input  addr_width  destination register of the long-latency result.
REQ-010 lu_data  input  width  long-latency result data.
REQ-011 lu_ready  output  1  queue can accept a long-latency result this cycle.
REQ-012 pipe_stall  output  1  queue full; upstream must hold the long-latency unit.
REQ-013 RegWrite  output  1  register-file write enable (registered).
REQ-014 W_addr  output  addr_width  register-file write address (registered).
REQ-015 W_data  output  width  register-file write data (registered).

Function
REQ-016 The block SHALL issue at most one register-file write per cycle; W_*/RegWrite SHALL appear one cycle after the winning request.
REQ-017 Priority SHALL be: (1) pipe_we with pipe_addr!=0; (2) queue head; (3) same-cycle accepted long-latency result when the queue is empty (direct bypass, 1-cycle latency).
REQ-018 A long-latency result SHALL be accepted when lu_valid && lu_ready; lu_ready SHALL equal (count<depth) && !rst.
REQ-019 An accepted result not written that cycle SHALL be pushed to the queue tail; results SHALL be written in acceptance order.
REQ-020 pipe_we with pipe_addr==0 SHALL produce no write, and the slot SHALL go to the queue or bypass.
REQ-021 An accepted long-latency result with lu_addr==0 SHALL be dropped: no queue entry, no write.
REQ-022 Simultaneous push and pop SHALL leave count unchanged; count SHALL never exceed depth or underflow.
REQ-023 pipe_stall SHALL equal (count==depth), driven from registered state only.
REQ-024 When no write is issued, RegWrite SHALL be 0 and W_addr/W_data SHALL hold their last values.

Reset
REQ-025 On rst: count=0, queue emptied, RegWrite=0, W_addr=0, W_data=0, pipe_stall=0, lu_ready=0; inputs during rst SHALL be ignored.
REQ-026 Reset mid-operation SHALL discard all queued results without writing them.

Configuration
REQ-027 With WB_FWD_EN defined, the block SHALL add inputs fwd_addr1/fwd_addr2 (addr_width) and outputs fwd_hit1/fwd_hit2 (1) and fwd_data1/fwd_data2 (width), combinationally reporting the youngest queued entry, else the pending registered write, matching a nonzero address.
REQ-028 Without WB_FWD_EN, these ports SHALL not exist and no forwarding logic SHALL be built.

Structure
REQ-029 A shared package regfile_pkg SHALL hold WIDTH, ADDR_WIDTH, REG_ZERO (5'd0) and the queue-entry typedef {addr, data}.
REQ-030 The queue SHALL be a sub-module wb_fifo (depth entries, push/pop/count, registered storage).

Verification
REQ-031 pipe_we=1, pipe_addr=8, pipe_data=0x1234 -> next cycle RegWrite=1, W_addr=8, W_data=0x1234.
REQ-032 Queue empty, pipe_we=0, lu_valid=1, lu_addr=16, lu_data=0xA5 -> next cycle write to 16 with 0xA5; count stays 0.
REQ-033 pipe_we=1 for 4 cycles while lu_valid=1 twice -> count=2, lu_ready=0, pipe_stall=1; after pipe_we drops, writes in acceptance order on the next two cycles, then count=0.
REQ-034 pipe_we=1, pipe_addr=0 with queue head {9,0x77} -> next cycle write to 9 with 0x77, no write to 0.
REQ-035 count=2, assert rst for one cycle -> RegWrite=0, count=0, pipe_stall=0; no queued result ever written.
REQ-036 With WB_FWD_EN: queue holds {17,0x5}, fwd_addr1=17, fwd_addr2=0 -> fwd_hit1=1, fwd_data1=0x5, fwd_hit2=0.
